// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control-decoder issue stage.
// The decoder itself lives outside; only its port widths are fixed here.
package ctrl_pkg;

  localparam int OP_W              = 7;
  localparam int CW_W              = 26;
  localparam int CW_ALWAYS_ONE_BIT = 23;

  typedef logic [OP_W-1:0] ctrl_op_t;
  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/ctrl_op_fifo.sv
// Opcode FIFO feeding the decoder; occupancy is tracked by an explicit level
// counter so full/empty never depend on pointer equality.
module ctrl_op_fifo
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  ctrl_op_t         push_op,
  input  logic             pop,
  output ctrl_op_t         head,
  output logic [LVL_W-1:0] level
);

  ctrl_op_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Callers only push below DEPTH and only pop above zero; flush wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_op;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ctrl_issue_stage.sv
// Wraps the combinational control decoder: buffers opcodes, feeds the FIFO head
// to the decoder, and registers the returned control word in a valid/ready stage.
module ctrl_issue_stage
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  ctrl_op_t         in_op,
  output ctrl_op_t         dec_op,
  input  ctrl_word_t       dec_word,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_word_t       out_word,
  output ctrl_op_t         out_op,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  out_state_t state;
  ctrl_op_t   fifo_head;
  logic       fifo_empty;
  logic       push;
  logic       load;

  ctrl_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .push_op (in_op),
    .pop     (load),
    .head    (fifo_head),
    .level   (level)
  );

  // Ready depends on occupancy alone, so out_ready never reaches in_ready.
  assign in_ready   = (level != FULL_LEVEL);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level == '0);
  assign dec_op     = fifo_empty ? '0 : fifo_head;
  assign load       = !fifo_empty & (!out_valid | out_ready);
  assign out_valid  = (state == OUT_FULL);

  // The word and opcode hold their last values when the stage empties or flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OUT_EMPTY;
      out_word <= '0;
      out_op   <= '0;
    end else if (flush) begin
      state <= OUT_EMPTY;
    end else if (load) begin
      state    <= OUT_FULL;
      out_word <= dec_word;
      out_op   <= fifo_head;
    end else if (state == OUT_FULL && out_ready) begin
      state <= OUT_EMPTY;
    end
  end

endmodule

// File: tb/tb_ctrl_issue_stage.sv
// Randomised bench for ctrl_issue_stage against a queue-based reference model,
// with a stand-in decoder that drives dec_word from dec_op.
module tb_ctrl_issue_stage;
  import ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  ctrl_op_t         in_op;
  ctrl_op_t         dec_op;
  ctrl_word_t       dec_word;
  logic             out_valid;
  logic             out_ready;
  ctrl_word_t       out_word;
  ctrl_op_t         out_op;
  logic [LVL_W-1:0] level;

  ctrl_op_t   mq[$];
  ctrl_op_t   acc_q[$];
  ctrl_op_t   rx_q[$];
  logic       m_valid;
  ctrl_op_t   m_op;
  ctrl_word_t m_word;
  int         vectors;
  int         miscompares;

  ctrl_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .dec_op    (dec_op),
    .dec_word  (dec_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_op    (out_op),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_word_t golden(input ctrl_op_t op);
    ctrl_word_t w;
    w = {op, op ^ 7'h2B, op[5:0], op[6:1] ^ 6'h15};
    w[CW_ALWAYS_ONE_BIT] = 1'b1;
    return w;
  endfunction

  always_comb dec_word = golden(dec_op);

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_op    = '0;
    m_word  = '0;
  endtask

  // Drives one cycle, records output handshakes and advances the model.
  task automatic cycle(input logic iv, input ctrl_op_t op, input logic ordy, input logic fl);
    bit push_ok;
    bit load;
    in_valid  = iv;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready) rx_q.push_back(out_op);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      push_ok = iv && (mq.size() < DEPTH);
      load    = (mq.size() != 0) && (!m_valid || ordy);
      if (load) begin
        m_op    = mq.pop_front();
        m_word  = golden(m_op);
        m_valid = 1'b1;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      if (push_ok) begin
        mq.push_back(op);
        acc_q.push_back(op);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; out_ready = 1'b0;
    model_reset();
    #12;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (level !== '0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (out_word !== '0) begin miscompares++; $display("[TB] FAIL reset_out_word: got %h expected 0", out_word); end
    vectors++; if (out_op !== '0) begin miscompares++; $display("[TB] FAIL reset_out_op: got %h expected 0", out_op); end
    vectors++; if (dec_op !== '0) begin miscompares++; $display("[TB] FAIL reset_dec_op: got %h expected 0", dec_op); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_op();
    cycle(1'b1, 7'h00, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid); end
    vectors++; if (level !== LVL_W'(1)) begin miscompares++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
    vectors++; if (out_op !== 7'h00) begin miscompares++; $display("[TB] FAIL single_op: got %h expected 00", out_op); end
    vectors++; if (out_word[CW_ALWAYS_ONE_BIT] !== 1'b1) begin miscompares++; $display("[TB] FAIL single_y23: got %b expected 1", out_word[CW_ALWAYS_ONE_BIT]); end
    vectors++; if (out_word !== golden(7'h00)) begin miscompares++; $display("[TB] FAIL single_word: got %h expected %h", out_word, golden(7'h00)); end
    cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_consumed: got %b expected 0", out_valid); end
    vectors++; if (out_word !== golden(7'h00)) begin miscompares++; $display("[TB] FAIL single_hold: got %h expected %h", out_word, golden(7'h00)); end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    acc_q.delete();
    for (int op = 1; op <= 127; op++) begin
      cycle(1'b1, ctrl_op_t'(op), 1'b1, 1'b0);
      vectors++; if (level > LVL_W'(1)) begin miscompares++; $display("[TB] FAIL b2b_level: got %0d expected <=1", level); end
      if (op >= 2) begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_bubble: got %b expected 1 at op %0d", out_valid, op); end
        vectors++; if (out_op !== ctrl_op_t'(op - 1)) begin miscompares++; $display("[TB] FAIL b2b_op: got %h expected %h", out_op, ctrl_op_t'(op - 1)); end
        vectors++; if (out_word !== golden(ctrl_op_t'(op - 1))) begin miscompares++; $display("[TB] FAIL b2b_word: got %h expected %h", out_word, golden(ctrl_op_t'(op - 1))); end
      end
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (rx_q.size() != 127) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 127", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 127; i++) begin
      vectors++; if (rx_q[i] !== ctrl_op_t'(i + 1)) begin miscompares++; $display("[TB] FAIL b2b_order: got %h expected %h", rx_q[i], ctrl_op_t'(i + 1)); end
    end
  endtask

  task automatic test_full();
    ctrl_op_t ops[6];
    int exp_level;
    acc_q.delete();
    for (int k = 0; k < 6; k++) ops[k] = ctrl_op_t'($urandom);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, ops[k], 1'b0, 1'b0);
      exp_level = (k == 0) ? 1 : ((k > 4) ? 4 : k);
      vectors++; if (level !== LVL_W'(exp_level)) begin miscompares++; $display("[TB] FAIL full_level: got %0d expected %0d", level, exp_level); end
      vectors++; if (in_ready !== (k < 4)) begin miscompares++; $display("[TB] FAIL full_in_ready: got %b expected %b", in_ready, k < 4); end
      if (k >= 1) begin
        vectors++; if (out_word !== golden(ops[0])) begin miscompares++; $display("[TB] FAIL full_stable_word: got %h expected %h", out_word, golden(ops[0])); end
        vectors++; if (out_op !== ops[0]) begin miscompares++; $display("[TB] FAIL full_stable_op: got %h expected %h", out_op, ops[0]); end
      end
    end
    vectors++; if (acc_q.size() != 5) begin miscompares++; $display("[TB] FAIL full_accepts: got %0d expected 5", acc_q.size()); end
  endtask

  task automatic test_drain_wrap();
    rx_q.delete();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 7'h2A, 1'b1, 1'b0);
      vectors++; if (level !== LVL_W'(3)) begin miscompares++; $display("[TB] FAIL wrap_level: got %0d expected 3", level); end
      vectors++; if (out_op !== m_op) begin miscompares++; $display("[TB] FAIL wrap_op: got %h expected %h", out_op, m_op); end
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (rx_q.size() != acc_q.size()) begin miscompares++; $display("[TB] FAIL wrap_count: got %0d expected %0d", rx_q.size(), acc_q.size()); end
    for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
      vectors++; if (rx_q[i] !== acc_q[i]) begin miscompares++; $display("[TB] FAIL wrap_order: got %h expected %h at %0d", rx_q[i], acc_q[i], i); end
    end
  endtask

  task automatic test_flush();
    ctrl_op_t first;
    first = ctrl_op_t'($urandom);
    cycle(1'b1, first, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, ctrl_op_t'($urandom), 1'b0, 1'b0);
    vectors++; if (level !== LVL_W'(3)) begin miscompares++; $display("[TB] FAIL flush_pre_level: got %0d expected 3", level); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_pre_valid: got %b expected 1", out_valid); end
    cycle(1'b1, 7'h55, 1'b0, 1'b1);
    vectors++; if (level !== '0) begin miscompares++; $display("[TB] FAIL flush_level: got %0d expected 0", level); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); end
    vectors++; if (dec_op !== '0) begin miscompares++; $display("[TB] FAIL flush_dec_op: got %h expected 0", dec_op); end
    vectors++; if (out_op !== first) begin miscompares++; $display("[TB] FAIL flush_hold_op: got %h expected %h", out_op, first); end
    cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (level !== '0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_discard: got level %0d valid %b expected 0 0", level, out_valid); end
  endtask

  task automatic test_async_reset();
    ctrl_op_t nxt;
    for (int k = 0; k < 3; k++) cycle(1'b1, ctrl_op_t'($urandom), 1'b0, 1'b0);
    vectors++; if (level !== LVL_W'(2) || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre: got level %0d valid %b expected 2 1", level, out_valid); end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_valid: got %b expected 0", out_valid); end
    vectors++; if (level !== '0) begin miscompares++; $display("[TB] FAIL areset_level: got %0d expected 0", level); end
    model_reset();
    #3;
    rst_n = 1'b1;
    nxt = ctrl_op_t'($urandom);
    cycle(1'b1, nxt, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_early: got %b expected 0", out_valid); end
    cycle(1'b0, 7'h00, 1'b1, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_op !== nxt) begin miscompares++; $display("[TB] FAIL areset_first: got valid %b op %h expected 1 %h", out_valid, out_op, nxt); end
    cycle(1'b0, 7'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, ctrl_op_t'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("[TB] FAIL rnd_valid: got %b expected %b", out_valid, m_valid); end
      vectors++; if (out_op !== m_op) begin miscompares++; $display("[TB] FAIL rnd_op: got %h expected %h", out_op, m_op); end
      vectors++; if (out_word !== m_word) begin miscompares++; $display("[TB] FAIL rnd_word: got %h expected %h", out_word, m_word); end
      vectors++; if (level !== LVL_W'(mq.size())) begin miscompares++; $display("[TB] FAIL rnd_level: got %0d expected %0d", level, mq.size()); end
      vectors++; if (in_ready !== (mq.size() < DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_in_ready: got %b expected %b", in_ready, mq.size() < DEPTH); end
      vectors++; if (dec_op !== ((mq.size() != 0) ? mq[0] : 7'h00)) begin miscompares++; $display("[TB] FAIL rnd_dec_op: got %h expected %h", dec_op, (mq.size() != 0) ? mq[0] : 7'h00); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_full();
    test_drain_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
